// File: rtl/ula_control_seq.sv
// rtl/ula_control_seq.sv - sequenced ALU-control decoder with valid/ready handshake
//
// Decodes OpALU/funct/imm_sel into an ALU control code. Single-cycle ops are
// presented one cycle after accept; MULT/DIV hold the block busy for
// MUL_CYCLES/DIV_CYCLES cycles before the result is presented.
//
// Optional feature macro: ULA_CTRL_SHIFT_EN (enables SLL/SRL/SRA decode;
// when undefined those functs decode as illegal).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   OpALU, funct, imm_sel request fields
//   out_valid / out_ready result handshake
//   inputALU, illegal     result (qualified by out_valid)
//   busy                  multi-cycle op in progress

module ula_control_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        OpALU,
    input  logic [5:0]        funct,
    input  logic [2:0]        imm_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] inputALU,
    output logic              illegal,
    output logic              busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
`ifdef ULA_CTRL_SHIFT_EN
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
`endif
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MULT = 4'b1101;
    localparam logic [3:0] C_DIV  = 4'b1110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [CTRL_W-1:0]  code_q,      code_d;
    logic               illegal_q,   illegal_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic [3:0]         dec_code;
    logic               dec_illegal;
    logic               dec_multi;
    logic [CNT_W-1:0]   dec_load;

    // Request decode; illegal requests fall through to code 0000.
    always_comb begin
        dec_code    = C_AND;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        dec_load    = MUL_LOAD;
        unique case (OpALU)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: dec_code = C_ADD;
                    6'b100010: dec_code = C_SUB;
                    6'b100100: dec_code = C_AND;
                    6'b100101: dec_code = C_OR;
                    6'b100110: dec_code = C_XOR;
                    6'b100111: dec_code = C_NOR;
                    6'b101010: dec_code = C_SLT;
`ifdef ULA_CTRL_SHIFT_EN
                    6'b000000: dec_code = C_SLL;
                    6'b000010: dec_code = C_SRL;
                    6'b000011: dec_code = C_SRA;
`endif
                    6'b011000: begin
                        dec_code  = C_MULT;
                        dec_multi = 1'b1;
                        dec_load  = MUL_LOAD;
                    end
                    6'b011010: begin
                        dec_code  = C_DIV;
                        dec_multi = 1'b1;
                        dec_load  = DIV_LOAD;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                case (imm_sel)
                    3'b000:  dec_code = C_ADD;
                    3'b001:  dec_code = C_AND;
                    3'b010:  dec_code = C_OR;
                    3'b011:  dec_code = C_SLT;
                    3'b100:  dec_code = C_XOR;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // A held result blocks new requests; a result being taken this edge
    // frees the slot so single-cycle ops stream without bubbles.
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    code_d    = CTRL_W'(dec_code);
                    illegal_d = dec_illegal;
                    if (dec_multi) begin
                        busy_d      = 1'b1;
                        out_valid_d = 1'b0;
                        cnt_d       = dec_load;
                        state_d     = S_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign inputALU  = code_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ula_control_seq.sv
// tb/tb_ula_control_seq.sv - self-checking bench for ula_control_seq

module tb_ula_control_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] OpALU;
    logic [5:0] funct;
    logic [2:0] imm_sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] inputALU;
    logic       illegal;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: a result slot plus a remaining-latency count.
    bit         m_valid;
    bit         m_ill;
    logic [3:0] m_code;
    int         m_left;

    ula_control_seq #(
        .CTRL_W     (4),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OpALU     (OpALU),
        .funct     (funct),
        .imm_sel   (imm_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inputALU  (inputALU),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ALU code table; cycles = 0 means single-cycle.
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                       input logic [2:0] imm, output logic [3:0] code,
                                       output bit ill, output int cycles);
        code = 4'd0; ill = 1'b0; cycles = 0;
        if (op == 2'd0) code = 4'd2;
        else if (op == 2'd1) code = 4'd6;
        else if (op == 2'd2) begin
            case (fn)
                6'd32: code = 4'd2;
                6'd34: code = 4'd6;
                6'd36: code = 4'd0;
                6'd37: code = 4'd1;
                6'd38: code = 4'd3;
                6'd39: code = 4'd12;
                6'd42: code = 4'd7;
`ifdef ULA_CTRL_SHIFT_EN
                6'd0:  code = 4'd8;
                6'd2:  code = 4'd9;
                6'd3:  code = 4'd10;
`endif
                6'd24: begin code = 4'd13; cycles = MUL_N; end
                6'd26: begin code = 4'd14; cycles = DIV_N; end
                default: ill = 1'b1;
            endcase
        end else begin
            case (imm)
                3'd0: code = 4'd2;
                3'd1: code = 4'd0;
                3'd2: code = 4'd1;
                3'd3: code = 4'd7;
                3'd4: code = 4'd3;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    function automatic bit exp_ready(input logic ordy);
        return (m_left == 0) && (!m_valid || ordy);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ill = 1'b0; m_code = 4'd0; m_left = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".inputALU"},  32'(inputALU),  32'(m_code));
        check({tag, ".illegal"},   32'(illegal),   32'(m_ill));
        check({tag, ".busy"},      32'(busy),      32'(m_left > 0));
    endtask

    // One clock: drive at posedge+1, check in_ready, advance edge, check outputs.
    task automatic step(input string tag, input logic v, input logic [1:0] op,
                        input logic [5:0] fn, input logic [2:0] imm, input logic ordy,
                        output bit acc);
        logic [3:0] c;
        bit         il;
        int         cyc;
        bit         rdy;
        in_valid = v; OpALU = op; funct = fn; imm_sel = imm; out_ready = ordy;
        #1;
        rdy = exp_ready(ordy);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (acc) begin
            ref_decode(op, fn, imm, c, il, cyc);
            m_code = c; m_ill = il;
            if (cyc > 0) begin
                m_left = cyc; m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
            end
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_cycles(input int n);
        bit a;
        for (int i = 0; i < n; i++) step("idle", 1'b0, 2'd0, 6'd0, 3'd0, 1'b1, a);
    endtask

    // Keep presenting a request until accepted, bounded.
    task automatic send(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [2:0] imm, input logic ordy);
        bit a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 40) begin
            step(tag, 1'b1, op, fn, imm, ordy, a);
            tries++;
        end
        if (!a) check({tag, ".accept_timeout"}, 32'd0, 32'd1);
    endtask

    logic [5:0] fn_tab [14] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                                6'd0, 6'd2, 6'd3, 6'd24, 6'd26, 6'd63, 6'd17};

    initial begin
        bit a;
        bit hold_v;
        logic [1:0] r_op;
        logic [5:0] r_fn;
        logic [2:0] r_imm;
        logic [5:0] tmp_fn;

        rst_n = 1'b0; in_valid = 1'b0; OpALU = 2'd0; funct = 6'd0;
        imm_sel = 3'd0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD via R-type, latency 1
        step("add", 1'b1, 2'd2, 6'd32, 3'd0, 1'b1, a);
        check("add.accept", 32'(a), 32'd1);

        // back-to-back single-cycle ops
        foreach (fn_tab[i]) begin
            if (i >= 1 && i <= 6) begin
                step("b2b", 1'b1, 2'd2, fn_tab[i], 3'd0, 1'b1, a);
                check("b2b.accept", 32'(a), 32'd1);
            end
        end
        idle_cycles(1);

        // MULT then DIV; model tracks busy/in_ready/code throughout
        send("mult", 2'd2, 6'd24, 3'd0, 1'b1);
        idle_cycles(MUL_N + 1);
        send("div", 2'd2, 6'd26, 3'd0, 1'b1);
        idle_cycles(DIV_N + 1);

        // XORI held for 3 cycles; pending ADD waits until out_ready rises
        send("xori", 2'd3, 6'd0, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 2'd0, 6'd0, 3'd0, 1'b0, a);
            check("stall.no_accept", 32'(a), 32'd0);
        end
        step("release", 1'b1, 2'd0, 6'd0, 3'd0, 1'b1, a);
        check("release.accept", 32'(a), 32'd1);

        // illegal funct and shift (illegal unless macro defined)
        send("ill", 2'd2, 6'd63, 3'd0, 1'b1);
        send("sll", 2'd2, 6'd0, 3'd0, 1'b1);
        send("illimm", 2'd3, 6'd0, 3'd7, 1'b1);
        idle_cycles(1);

        // reset in the middle of DIV
        send("div2", 2'd2, 6'd26, 3'd0, 1'b1);
        idle_cycles(3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step("postrst", 1'b1, 2'd2, 6'd32, 3'd0, 1'b1, a);
        check("postrst.accept", 32'(a), 32'd1);

        // randomized traffic; requester holds a request until accepted
        hold_v = 1'b0; r_op = 2'd0; r_fn = 6'd0; r_imm = 3'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold_v) begin
                r_op = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) r_fn = 6'($urandom);
                else begin
                    tmp_fn = fn_tab[$urandom_range(0, 13)];
                    r_fn = tmp_fn;
                end
                r_imm = 3'($urandom);
                hold_v = ($urandom_range(0, 3) != 0);
            end
            step("rand", hold_v, r_op, r_fn, r_imm, 1'($urandom_range(0, 3) != 0), a);
            if (a) hold_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
